// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Drives the ALU operand mux select lines for an accepted op,
//                waits SETTLE cycles, then samples and returns the mux result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    output logic             sel_s1,
    output logic             sel_s2,
    input  logic [WIDTH-1:0] mux_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] C_SETTLE = 4'(SETTLE);

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [1:0]       r_op, w_op_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
    logic [1:0]       r_rsp_op, w_rsp_op_nxt;
    logic             r_rsp_zero, w_rsp_zero_nxt;
    logic             w_accept;

    // A held result can be retired and a new op accepted on the same edge.
    assign req_ready = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && rsp_ready);
    assign w_accept  = req_valid && req_ready;

    assign sel_s1    = r_sel[0];
    assign sel_s2    = r_sel[1];
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_op    = r_rsp_op;
    assign rsp_zero  = r_rsp_zero;
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sel_nxt       = r_sel;
        w_op_nxt        = r_op;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_op_nxt    = r_rsp_op;
        w_rsp_zero_nxt  = r_rsp_zero;

        case (r_state)
            ST_IDLE: begin
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_rsp_data_nxt  = mux_out;
                    w_rsp_op_nxt    = r_op;
                    w_rsp_zero_nxt  = (mux_out == '0);
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Acceptance overrides the HOLD->IDLE transition for back-to-back ops.
        if (w_accept) begin
            w_sel_nxt   = req_op;
            w_op_nxt    = req_op;
            w_cnt_nxt   = C_SETTLE;
            w_state_nxt = ST_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        assert (SETTLE >= 1 && SETTLE <= 15);
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_sel       <= 2'b00;
            r_op        <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_op    <= 2'b00;
            r_rsp_zero  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_op        <= w_op_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_op    <= w_rsp_op_nxt;
            r_rsp_zero  <= w_rsp_zero_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed bench for alu_op_sequencer at SETTLE = 1, 3 and 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid [3];
    logic       req_ready [3];
    logic [1:0] req_op    [3];
    logic       sel_s1    [3];
    logic       sel_s2    [3];
    logic [3:0] mux_out   [3];
    logic       rsp_valid [3];
    logic       rsp_ready [3];
    logic [3:0] rsp_data  [3];
    logic [1:0] rsp_op    [3];
    logic       rsp_zero  [3];
    logic       busy      [3];
    logic [3:0] data      [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] mux_in;
        logic [3:0] exp_data;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [6];

    logic       mon_en = 1'b0;
    logic [3:0] mon_data [$];
    logic [1:0] mon_op   [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_mux
        assign mux_out[g] = data[{sel_s2[g], sel_s1[g]}];
    end

    alu_op_sequencer #(.WIDTH(4), .SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .sel_s1(sel_s1[0]), .sel_s2(sel_s2[0]), .mux_out(mux_out[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_op(rsp_op[0]), .rsp_zero(rsp_zero[0]), .busy(busy[0]));

    alu_op_sequencer #(.WIDTH(4), .SETTLE(3)) u_dut_s3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .sel_s1(sel_s1[1]), .sel_s2(sel_s2[1]), .mux_out(mux_out[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_op(rsp_op[1]), .rsp_zero(rsp_zero[1]), .busy(busy[1]));

    alu_op_sequencer #(.WIDTH(4), .SETTLE(4)) u_dut_s4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_op(req_op[2]), .sel_s1(sel_s1[2]), .sel_s2(sel_s2[2]), .mux_out(mux_out[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2]),
        .rsp_op(rsp_op[2]), .rsp_zero(rsp_zero[2]), .busy(busy[2]));

    always @(negedge clk) begin
        if (mon_en && rsp_valid[0] && rsp_ready[0]) begin
            mon_data.push_back(rsp_data[0]);
            mon_op.push_back(rsp_op[0]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until rsp_valid is seen on instance i, giving up after max edges.
    task automatic wait_valid(input int i, input int max);
        int n = 0;
        while (!rsp_valid[i] && n < max) begin
            tick();
            n++;
        end
        chk("wait_rsp_valid", 32'(rsp_valid[i]), 32'd1);
    endtask

    initial begin
        int vcnt;
        logic [3:0] exp_sweep [4];

        vecs[0] = '{op: 2'd0, mux_in: 4'h1, exp_data: 4'h1, exp_zero: 1'b0};
        vecs[1] = '{op: 2'd1, mux_in: 4'h2, exp_data: 4'h2, exp_zero: 1'b0};
        vecs[2] = '{op: 2'd2, mux_in: 4'h4, exp_data: 4'h4, exp_zero: 1'b0};
        vecs[3] = '{op: 2'd3, mux_in: 4'h8, exp_data: 4'h8, exp_zero: 1'b0};
        vecs[4] = '{op: 2'd2, mux_in: 4'h0, exp_data: 4'h0, exp_zero: 1'b1};
        vecs[5] = '{op: 2'd3, mux_in: 4'hF, exp_data: 4'hF, exp_zero: 1'b0};
        exp_sweep = '{4'h1, 4'h2, 4'h4, 4'h8};

        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_op[i]    = 2'b00;
            rsp_ready[i] = 1'b0;
        end
        for (int j = 0; j < 4; j++) data[j] = 4'h0;

        // Reset
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst_sel", 32'({sel_s2[i], sel_s1[i]}), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data[i]), 32'd0);
        end
        rst = 1'b0;

        // SETTLE=1, op 2 -> 0xA
        data[2] = 4'hA;
        req_op[0] = 2'd2;
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        chk("s1_sel_s2", 32'(sel_s2[0]), 32'd1);
        chk("s1_sel_s1", 32'(sel_s1[0]), 32'd0);
        chk("s1_wait_valid", 32'(rsp_valid[0]), 32'd0);
        chk("s1_wait_ready", 32'(req_ready[0]), 32'd0);
        tick();
        chk("s1_valid", 32'(rsp_valid[0]), 32'd1);
        chk("s1_data", 32'(rsp_data[0]), 32'hA);
        chk("s1_op", 32'(rsp_op[0]), 32'd2);
        chk("s1_zero", 32'(rsp_zero[0]), 32'd0);
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        chk("s1_done_valid", 32'(rsp_valid[0]), 32'd0);
        chk("s1_done_busy", 32'(busy[0]), 32'd0);
        chk("s1_data_kept", 32'(rsp_data[0]), 32'hA);

        // Vector table on SETTLE=1, other channels loaded with decoys
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < 4; j++) data[j] = ~vecs[v].mux_in;
            data[vecs[v].op] = vecs[v].mux_in;
            req_op[0] = vecs[v].op;
            req_valid[0] = 1'b1;
            tick();
            req_valid[0] = 1'b0;
            tick();
            chk("vec_valid", 32'(rsp_valid[0]), 32'd1);
            chk("vec_data", 32'(rsp_data[0]), 32'(vecs[v].exp_data));
            chk("vec_op", 32'(rsp_op[0]), 32'(vecs[v].op));
            chk("vec_zero", 32'(rsp_zero[0]), 32'(vecs[v].exp_zero));
            rsp_ready[0] = 1'b1;
            tick();
            rsp_ready[0] = 1'b0;
        end

        // SETTLE=3, op 1 -> 0x0, exact latency
        data[1] = 4'h0;
        req_op[1] = 2'd1;
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("s3_wait_valid", 32'(rsp_valid[1]), 32'd0);
            chk("s3_wait_ready", 32'(req_ready[1]), 32'd0);
            tick();
        end
        chk("s3_valid", 32'(rsp_valid[1]), 32'd1);
        chk("s3_data", 32'(rsp_data[1]), 32'h0);
        chk("s3_zero", 32'(rsp_zero[1]), 32'd1);
        chk("s3_op", 32'(rsp_op[1]), 32'd1);
        data[1] = 4'hF;
        tick();
        chk("s3_no_comb_path", 32'(rsp_data[1]), 32'h0);
        chk("s3_zero_held", 32'(rsp_zero[1]), 32'd1);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;

        // Backpressure then back-to-back acceptance
        data[0] = 4'h7;
        req_op[1] = 2'd0;
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        wait_valid(1, 10);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("bp_data", 32'(rsp_data[1]), 32'h7);
            chk("bp_op", 32'(rsp_op[1]), 32'd0);
            chk("bp_ready", 32'(req_ready[1]), 32'd0);
            tick();
        end
        data[3] = 4'h5;
        req_op[1] = 2'd3;
        req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b1;
        #1;
        chk("b2b_ready_comb", 32'(req_ready[1]), 32'd1);
        tick();
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;
        chk("b2b_valid_drop", 32'(rsp_valid[1]), 32'd0);
        chk("b2b_busy", 32'(busy[1]), 32'd1);
        chk("b2b_sel", 32'({sel_s2[1], sel_s1[1]}), 32'd3);
        tick();
        tick();
        chk("b2b_early", 32'(rsp_valid[1]), 32'd0);
        tick();
        chk("b2b_valid", 32'(rsp_valid[1]), 32'd1);
        chk("b2b_data", 32'(rsp_data[1]), 32'h5);
        chk("b2b_op", 32'(rsp_op[1]), 32'd3);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;

        // SETTLE=4, reset during second WAIT cycle
        data[2] = 4'h9;
        req_op[2] = 2'd2;
        req_valid[2] = 1'b1;
        rsp_ready[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid[2]) vcnt++;
            tick();
        end
        chk("rstw_no_valid", 32'(vcnt), 32'd0);
        chk("rstw_sel", 32'({sel_s2[2], sel_s1[2]}), 32'd0);
        chk("rstw_busy", 32'(busy[2]), 32'd0);
        data[1] = 4'h3;
        req_op[2] = 2'd1;
        req_valid[2] = 1'b1;
        rsp_ready[2] = 1'b0;
        tick();
        req_valid[2] = 1'b0;
        wait_valid(2, 10);
        chk("rstw_next_data", 32'(rsp_data[2]), 32'h3);
        chk("rstw_next_op", 32'(rsp_op[2]), 32'd1);
        rsp_ready[2] = 1'b1;
        tick();
        rsp_ready[2] = 1'b0;

        // Back-to-back sweep, rsp_ready tied high
        data[0] = 4'h1;
        data[1] = 4'h2;
        data[2] = 4'h4;
        data[3] = 4'h8;
        rsp_ready[0] = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            req_op[0] = 2'(k);
            req_valid[0] = 1'b1;
            while (!req_ready[0] && n < 10) begin
                tick();
                n++;
            end
            if (n >= 10) chk("sweep_accept_timeout", 32'(req_ready[0]), 32'd1);
            tick();
        end
        req_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        mon_en = 1'b0;
        rsp_ready[0] = 1'b0;
        chk("sweep_count", 32'(mon_data.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < mon_data.size()) begin
                chk("sweep_data", 32'(mon_data[k]), 32'(exp_sweep[k]));
                chk("sweep_op", 32'(mon_op[k]), 32'(k));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
